// File: rtl/contador16_cascade_pkg.sv
// contador16_cascade_pkg
//   Shared constants for the 16-bit cascaded counter: the mode encodings
//   used on MODO, the nibble-stage width and the number of stages.
package contador16_cascade_pkg;

   localparam int unsigned STAGE_W    = 4;
   localparam int unsigned NUM_STAGES = 4;

   typedef logic [1:0] modo_t;

   localparam modo_t MODE_UP1  = 2'b00;
   localparam modo_t MODE_DN1  = 2'b01;
   localparam modo_t MODE_DN3  = 2'b10;
   localparam modo_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/contador16_cascade_if.sv
// contador16_cascade_if
//   Bus between the 16-bit counter and the system driving/monitoring it.
//   master: drives ENB, MODO, entrada; observes salida and the four RCOs.
//   slave : the counter itself.
//   Signals:
//     ENB     global count/load enable
//     MODO    00 up+1, 01 down-1, 10 down-3, 11 parallel load
//     entrada parallel load data
//     salida  registered counter value
//     RCO, RCO162, RCO163, RCO164  carry/borrow out of stages 0..3
interface contador16_cascade_if;
   import contador16_cascade_pkg::*;

   logic        ENB;
   modo_t       MODO;
   logic [15:0] entrada;
   logic [15:0] salida;
   logic        RCO;
   logic        RCO162;
   logic        RCO163;
   logic        RCO164;

   modport master (
      output ENB, MODO, entrada,
      input  salida, RCO, RCO162, RCO163, RCO164
   );

   modport slave (
      input  ENB, MODO, entrada,
      output salida, RCO, RCO162, RCO163, RCO164
   );

endinterface

// File: rtl/contador_nibble.sv
// contador_nibble
//   One 4-bit counter stage. Steps Q on the rising CLK edge when EN=1:
//   00 +1, 01 -1, 10 -3, 11 load D. Holds otherwise.
//   RCO is combinational and only asserted while EN=1; it flags that this
//   stage wraps on the coming edge so the next stage can step together.
//   Ports:
//     CLK      rising-edge clock
//     RESET_L  asynchronous active-low reset, clears Q
//     EN       stage enable
//     MODO     stage mode
//     D        load data
//     Q        registered stage value
//     RCO      carry/borrow out
module contador_nibble
   import contador16_cascade_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET_L,
   input  logic               EN,
   input  modo_t              MODO,
   input  logic [STAGE_W-1:0] D,
   output logic [STAGE_W-1:0] Q,
   output logic               RCO
);

   logic [STAGE_W-1:0] q_q, q_d;

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   always_comb begin
      q_d = q_q;
      RCO = 1'b0;
      if (EN) begin
         unique case (MODO)
            MODE_UP1: begin
               q_d = q_q + 4'd1;
               RCO = (q_q == 4'hF);
            end
            MODE_DN1: begin
               q_d = q_q - 4'd1;
               RCO = (q_q == 4'h0);
            end
            MODE_DN3: begin
               q_d = q_q - 4'd3;
               RCO = (q_q < 4'd3);
            end
            MODE_LOAD: begin
               q_d = D;
               RCO = 1'b0;
            end
            default: begin
               q_d = q_q;
               RCO = 1'b0;
            end
         endcase
      end
   end

   assign Q = q_q;

endmodule

// File: rtl/contador16_cascade.sv
// contador16_cascade
//   16-bit multi-mode synchronous counter built from four contador_nibble
//   stages chained through their RCO outputs. Because each RCO reflects the
//   current cycle, all stages step on the same edge and the 16-bit result
//   is exact binary +1 / -1 / -3 / load.
//   Ports:
//     CLK      rising-edge clock
//     RESET_L  asynchronous active-low reset (salida -> 0)
//     bus      slave side of contador16_cascade_if (ENB, MODO, entrada in;
//              salida, RCO, RCO162, RCO163, RCO164 out)
module contador16_cascade
   import contador16_cascade_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RESET_L,
   contador16_cascade_if.slave  bus
);

   // Scalars per stage (rather than vectors) keep the en/rco chain free of
   // apparent combinational self-loops.
   logic               en0, en1, en2, en3;
   logic               rco0, rco1, rco2, rco3;
   logic [STAGE_W-1:0] q0, q1, q2, q3;
   modo_t              modo_hi;
   logic               is_load;

   always_comb begin
      is_load = (bus.MODO == MODE_LOAD);
      // Down-3 only borrows at most one from the upper nibbles.
      modo_hi = (bus.MODO == MODE_DN3) ? MODE_DN1 : bus.MODO;
      en0     = bus.ENB;
      en1     = is_load ? bus.ENB : (bus.ENB & rco0);
      en2     = is_load ? bus.ENB : (bus.ENB & rco1);
      en3     = is_load ? bus.ENB : (bus.ENB & rco2);
   end

   contador_nibble u_stage0 (
      .CLK     (CLK),
      .RESET_L (RESET_L),
      .EN      (en0),
      .MODO    (bus.MODO),
      .D       (bus.entrada[3:0]),
      .Q       (q0),
      .RCO     (rco0)
   );

   contador_nibble u_stage1 (
      .CLK     (CLK),
      .RESET_L (RESET_L),
      .EN      (en1),
      .MODO    (modo_hi),
      .D       (bus.entrada[7:4]),
      .Q       (q1),
      .RCO     (rco1)
   );

   contador_nibble u_stage2 (
      .CLK     (CLK),
      .RESET_L (RESET_L),
      .EN      (en2),
      .MODO    (modo_hi),
      .D       (bus.entrada[11:8]),
      .Q       (q2),
      .RCO     (rco2)
   );

   contador_nibble u_stage3 (
      .CLK     (CLK),
      .RESET_L (RESET_L),
      .EN      (en3),
      .MODO    (modo_hi),
      .D       (bus.entrada[15:12]),
      .Q       (q3),
      .RCO     (rco3)
   );

   assign bus.salida = {q3, q2, q1, q0};
   assign bus.RCO    = rco0;
   assign bus.RCO162 = rco1;
   assign bus.RCO163 = rco2;
   assign bus.RCO164 = rco3;

endmodule

// File: tb/tb_contador16_cascade.sv
// tb_contador16_cascade
//   Directed, table-driven bench for contador16_cascade. Each vector drives
//   ENB/MODO/entrada after a falling edge, checks the pre-edge RCOs, then
//   checks salida just after the rising edge. Reset cases are hand-written.
module tb_contador16_cascade;
   import contador16_cascade_pkg::*;

   logic CLK = 1'b0;
   logic RESET_L;

   always #5 CLK = ~CLK;

   contador16_cascade_if bus ();

   contador16_cascade dut (
      .CLK     (CLK),
      .RESET_L (RESET_L),
      .bus     (bus)
   );

   typedef struct {
      logic        enb;
      modo_t       modo;
      logic [15:0] din;
      logic [3:0]  exp_rco;  // {RCO164, RCO163, RCO162, RCO} before the edge
      logic [15:0] exp_q;    // salida after the edge
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [3:0] rco_vec();
      return {bus.RCO164, bus.RCO163, bus.RCO162, bus.RCO};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic enb, input modo_t modo, input logic [15:0] din,
                      input logic [3:0] rco, input logic [15:0] q);
      vec_t v;
      v.enb = enb; v.modo = modo; v.din = din; v.exp_rco = rco; v.exp_q = q;
      vecs.push_back(v);
   endtask

   initial begin
      bus.ENB     = 1'b0;
      bus.MODO    = MODE_UP1;
      bus.entrada = 16'h0000;
      RESET_L     = 1'b0;
      #1;
      check("reset_salida", bus.salida, 16'h0000);
      check("reset_rco", {12'h0, rco_vec()}, 16'h0000);

      //  enb  mode       entrada   rco      salida
      add(1'b1, MODE_LOAD, 16'hA5C3, 4'b0000, 16'hA5C3);
      add(1'b0, MODE_LOAD, 16'h1234, 4'b0000, 16'hA5C3);  // load disabled
      add(1'b1, MODE_LOAD, 16'hFFFE, 4'b0000, 16'hFFFE);
      add(1'b1, MODE_UP1,  16'h0000, 4'b0000, 16'hFFFF);
      add(1'b1, MODE_UP1,  16'h0000, 4'b1111, 16'h0000);  // full wrap
      add(1'b1, MODE_LOAD, 16'h000F, 4'b0000, 16'h000F);
      add(1'b1, MODE_UP1,  16'h0000, 4'b0001, 16'h0010);
      add(1'b1, MODE_UP1,  16'h0000, 4'b0000, 16'h0011);
      add(1'b1, MODE_LOAD, 16'h0100, 4'b0000, 16'h0100);
      add(1'b1, MODE_DN1,  16'h0000, 4'b0011, 16'h00FF);
      add(1'b1, MODE_LOAD, 16'h0000, 4'b0000, 16'h0000);
      add(1'b1, MODE_DN1,  16'h0000, 4'b1111, 16'hFFFF);  // underflow
      add(1'b1, MODE_LOAD, 16'h0002, 4'b0000, 16'h0002);
      add(1'b1, MODE_DN3,  16'h0000, 4'b1111, 16'hFFFF);
      add(1'b1, MODE_DN3,  16'h0000, 4'b0000, 16'hFFFC);
      add(1'b1, MODE_LOAD, 16'h0013, 4'b0000, 16'h0013);
      add(1'b1, MODE_DN3,  16'h0000, 4'b0000, 16'h0010);
      add(1'b1, MODE_LOAD, 16'h0001, 4'b0000, 16'h0001);
      add(1'b1, MODE_DN3,  16'h0000, 4'b1111, 16'hFFFE);
      add(1'b1, MODE_LOAD, 16'h0007, 4'b0000, 16'h0007);
      add(1'b0, MODE_UP1,  16'h0000, 4'b0000, 16'h0007);  // hold x3
      add(1'b0, MODE_UP1,  16'h0000, 4'b0000, 16'h0007);
      add(1'b0, MODE_UP1,  16'h0000, 4'b0000, 16'h0007);
      add(1'b1, MODE_UP1,  16'h0000, 4'b0000, 16'h0008);
      add(1'b1, MODE_LOAD, 16'h0000, 4'b0000, 16'h0000);
      add(1'b0, MODE_DN1,  16'h0000, 4'b0000, 16'h0000);  // EN=0 masks RCO
      add(1'b1, MODE_LOAD, 16'h00F0, 4'b0000, 16'h00F0);
      add(1'b1, MODE_DN3,  16'h0000, 4'b0001, 16'h00ED);  // borrow into nibble 1

      @(negedge CLK);
      RESET_L = 1'b1;

      foreach (vecs[i]) begin
         @(negedge CLK);
         bus.ENB     = vecs[i].enb;
         bus.MODO    = vecs[i].modo;
         bus.entrada = vecs[i].din;
         #1;
         check($sformatf("vec%0d_rco", i), {12'h0, rco_vec()}, {12'h0, vecs[i].exp_rco});
         @(posedge CLK);
         #1;
         check($sformatf("vec%0d_salida", i), bus.salida, vecs[i].exp_q);
      end

      // Asynchronous reset mid-count from 0x1234.
      @(negedge CLK);
      bus.ENB = 1'b1; bus.MODO = MODE_LOAD; bus.entrada = 16'h1234;
      @(posedge CLK);
      #1;
      check("pre_reset_load", bus.salida, 16'h1234);
      @(negedge CLK);
      bus.MODO = MODE_DN1;
      #1;
      RESET_L = 1'b0;
      #1;
      check("async_reset_salida", bus.salida, 16'h0000);
      check("reset_rco_dn1", {12'h0, rco_vec()}, 16'h000F);
      bus.MODO = MODE_UP1;
      #1;
      check("reset_rco_up1", {12'h0, rco_vec()}, 16'h0000);
      // Reset overrides a load across a clock edge.
      bus.MODO = MODE_LOAD; bus.entrada = 16'hFFFF;
      @(posedge CLK);
      #1;
      check("reset_over_load", bus.salida, 16'h0000);
      @(negedge CLK);
      RESET_L  = 1'b1;
      bus.MODO = MODE_UP1;
      @(posedge CLK);
      #1;
      check("resume_after_reset", bus.salida, 16'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
